// File: rtl/gb_video_pkg.sv
// Shared Game Boy video constants: framebuffer geometry, shade type, palette
// and swap-FSM state encoding.
package gb_video_pkg;

   localparam int GB_W      = 160;
   localparam int GB_H      = 144;
   localparam int FB_ADDR_W = 15;

   typedef logic [1:0]  shade_t;
   typedef logic [23:0] rgb_t;

   // Indexed by shade: 0 is the lightest green, 3 the darkest.
   localparam logic [3:0][23:0] PALETTE = {
      24'h081820, 24'h346856, 24'h88C070, 24'hE0F8D0
   };

   typedef enum logic {
      SW_IDLE    = 1'b0,
      SW_PENDING = 1'b1
   } swap_state_e;

endpackage

// File: rtl/gb_scanout_ctrl_if.sv
// Scan-out bus: hdmi scan position in, framebuffer read port, rgb out and the
// frame-writer swap handshake.
interface gb_scanout_ctrl_if;
   import gb_video_pkg::*;

   logic [9:0]           cx;
   logic [9:0]           cy;
   logic [9:0]           screen_width;
   logic [9:0]           screen_height;
   logic [FB_ADDR_W-1:0] fb_rd_addr;
   logic                 fb_rd_bank;
   shade_t               fb_rd_data;
   rgb_t                 rgb;
   logic                 wr_bank;
   logic                 wr_frame_done;
   logic                 swap_ack;
   logic [7:0]           drop_count;

   modport master (
      output cx, cy, screen_width, screen_height, fb_rd_data, wr_frame_done,
      input  fb_rd_addr, fb_rd_bank, rgb, wr_bank, swap_ack, drop_count
   );

   modport slave (
      input  cx, cy, screen_width, screen_height, fb_rd_data, wr_frame_done,
      output fb_rd_addr, fb_rd_bank, rgb, wr_bank, swap_ack, drop_count
   );

endinterface

// File: rtl/gb_swap_ctrl.sv
// Front/back bank ownership: a finished frame waits in PENDING and is only
// promoted to display at vblank start, so scan-out never tears.
module gb_swap_ctrl
   import gb_video_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       vblank_start_i,
   input  logic       frame_done_i,
   output logic       rd_bank_o,
   output logic       wr_bank_o,
   output logic       swap_ack_o,
   output logic [7:0] drop_count_o
);

   swap_state_e state_q;
   logic        bank_q;
   logic        ack_q;
   logic [7:0]  drop_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= SW_IDLE;
         bank_q  <= 1'b0;
         ack_q   <= 1'b0;
         drop_q  <= 8'd0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            // A completion landing on vblank start is not shown until the next one.
            SW_IDLE: if (frame_done_i) state_q <= SW_PENDING;
            SW_PENDING: begin
               if (frame_done_i && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
               if (vblank_start_i) begin
                  bank_q  <= ~bank_q;
                  ack_q   <= 1'b1;
                  state_q <= SW_IDLE;
               end
            end
            default: state_q <= SW_IDLE;
         endcase
      end
   end

   assign rd_bank_o    = bank_q;
   assign wr_bank_o    = ~bank_q;
   assign swap_ack_o   = ack_q;
   assign drop_count_o = drop_q;

endmodule

// File: rtl/gb_scanout_ctrl.sv
// Game Boy scan-out: maps the hdmi (cx, cy) onto the integer-scaled 160x144
// window, fetches shades, converts to rgb and paints the border elsewhere.
module gb_scanout_ctrl
   import gb_video_pkg::*;
#(
   parameter int unsigned SCALE      = 3,
   parameter int unsigned H_OFFSET   = 80,
   parameter int unsigned V_OFFSET   = 24,
   parameter logic [23:0] BORDER_RGB = 24'h000000
) (
   input logic              clk_pixel,
   input logic              reset_n,
   gb_scanout_ctrl_if.slave bus
);

   localparam int STAGES = 1;
   localparam int SUB_W  = (SCALE > 1) ? $clog2(SCALE) : 1;

   localparam logic [9:0]           H_LO       = 10'(H_OFFSET);
   localparam logic [9:0]           H_HI       = 10'(H_OFFSET + GB_W * SCALE);
   localparam logic [9:0]           V_LO       = 10'(V_OFFSET);
   localparam logic [9:0]           V_HI       = 10'(V_OFFSET + GB_H * SCALE);
   localparam logic [SUB_W-1:0]     SUB_MAX    = SUB_W'(SCALE - 1);
   localparam logic [FB_ADDR_W-1:0] ROW_STRIDE = FB_ADDR_W'(GB_W);

   logic [SUB_W-1:0]     x_sub_q, x_sub_d, y_sub_q, y_sub_d, cur_xsub;
   logic [7:0]           gb_x_q, gb_x_d, gb_y_q, gb_y_d, cur_gbx;
   logic [FB_ADDR_W-1:0] row_base_q, row_base_d;
   logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
   logic                 row_ok_q, row_ok_d;
   logic [STAGES:0]      vld_pipe_q;
   rgb_t                 rgb_q;

   logic in_win, win_eff, row_start, row_step, col_start, vblank_start;

   always_comb begin
      in_win = (bus.cx >= H_LO) && (bus.cx < H_HI) && (bus.cx < bus.screen_width) &&
               (bus.cy >= V_LO) && (bus.cy < V_HI);
      row_start    = (bus.cx == 10'd0) && (bus.cy == V_LO);
      vblank_start = (bus.cx == 10'd0) && (bus.cy == bus.screen_height);
      col_start    = (bus.cx == H_LO);
      // After a reset the counters are meaningless until the window's first row.
      win_eff   = in_win && row_ok_q;
      row_step  = (bus.cx == 10'd0) && (bus.cy > V_LO) && (bus.cy < V_HI) && row_ok_q;

      // Column counters are restarted in the same cycle the first column is fetched.
      cur_xsub = col_start ? '0 : x_sub_q;
      cur_gbx  = col_start ? '0 : gb_x_q;

      x_sub_d    = x_sub_q;
      gb_x_d     = gb_x_q;
      y_sub_d    = y_sub_q;
      gb_y_d     = gb_y_q;
      row_base_d = row_base_q;
      row_ok_d   = row_ok_q;
      fb_addr_d  = fb_addr_q;

      if (row_start) begin
         row_ok_d   = 1'b1;
         y_sub_d    = '0;
         gb_y_d     = 8'd0;
         row_base_d = '0;
      end else if (row_step) begin
         if (y_sub_q == SUB_MAX) begin
            y_sub_d    = '0;
            gb_y_d     = gb_y_q + 8'd1;
            row_base_d = row_base_q + ROW_STRIDE;
         end else begin
            y_sub_d = y_sub_q + SUB_W'(1);
         end
      end

      if (win_eff) begin
         fb_addr_d = row_base_q + FB_ADDR_W'(cur_gbx);
         if (cur_xsub == SUB_MAX) begin
            x_sub_d = '0;
            gb_x_d  = cur_gbx + 8'd1;
         end else begin
            x_sub_d = cur_xsub + SUB_W'(1);
            gb_x_d  = cur_gbx;
         end
      end else if (col_start) begin
         x_sub_d = '0;
         gb_x_d  = 8'd0;
      end
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         x_sub_q    <= '0;
         gb_x_q     <= 8'd0;
         y_sub_q    <= '0;
         gb_y_q     <= 8'd0;
         row_base_q <= '0;
         row_ok_q   <= 1'b0;
         fb_addr_q  <= '0;
         vld_pipe_q <= '0;
         rgb_q      <= 24'h000000;
      end else begin
         x_sub_q    <= x_sub_d;
         gb_x_q     <= gb_x_d;
         y_sub_q    <= y_sub_d;
         gb_y_q     <= gb_y_d;
         row_base_q <= row_base_d;
         row_ok_q   <= row_ok_d;
         fb_addr_q  <= fb_addr_d;
         vld_pipe_q <= {vld_pipe_q[STAGES-1:0], win_eff};
         // fb_rd_data lines up with the last valid stage: memory adds the middle cycle.
         rgb_q      <= vld_pipe_q[STAGES] ? PALETTE[bus.fb_rd_data] : BORDER_RGB;
      end
   end

   assign bus.fb_rd_addr = fb_addr_q;
   assign bus.rgb        = rgb_q;

   gb_swap_ctrl u_swap (
      .clk_i          (clk_pixel),
      .rst_ni         (reset_n),
      .vblank_start_i (vblank_start),
      .frame_done_i   (bus.wr_frame_done),
      .rd_bank_o      (bus.fb_rd_bank),
      .wr_bank_o      (bus.wr_bank),
      .swap_ack_o     (bus.swap_ack),
      .drop_count_o   (bus.drop_count)
   );

endmodule
